xnor_pattern_matcher: RTL and testbench

- Parametrised streaming comparator built on bitwise XNOR.
- Each accepted input word is XNORed against a programmable pattern, gated by a compare mask, and registered.
- Produces a per-bit equality vector, a full-match flag, a consecutive-match (run) detector and a saturating match counter.
- Sits in the CA datapath lab set as the sequential successor to the single-bit XNOR gate; feeds comparison and pattern-detect stages.

---
 rtl/xnor_pattern_matcher_pkg.sv | 10 +
 rtl/xnor_pattern_matcher_if.sv | 15 +
 rtl/xnor_vec.sv | 11 +
 rtl/xnor_pattern_matcher.sv | 85 ++++++++
 tb/tb_xnor_pattern_matcher.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_pattern_matcher_pkg.sv
// xnor_pkg: shared constants, run-FSM state type and popcount width helper for xnor_pattern_matcher.
package xnor_pkg;
    localparam int WIDTH_D   = 8;
    localparam int RUN_LEN_D = 3;
    localparam int CNT_W_D   = 8;
    typedef enum logic [1:0] {IDLE, COUNT, HIT} state_t;
    function automatic int pop_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/xnor_pattern_matcher_if.sv
// xnor_pattern_matcher_if: valid/ready input stream and registered result stream.
interface xnor_pattern_matcher_if import xnor_pkg::*; #(parameter int WIDTH = WIDTH_D) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] xnor_out;
    logic             match;
    logic             run_hit;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, xnor_out, match, run_hit);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, xnor_out, match, run_hit);
endinterface

// File: rtl/xnor_vec.sv
// xnor_vec: bitwise XNOR of data against pattern plus masked full-match reduction.
module xnor_vec import xnor_pkg::*; #(parameter int WIDTH = WIDTH_D) (
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] xnor_bits,
    output logic             match
);
    assign xnor_bits = data ~^ pattern;
    assign match     = &(xnor_bits | ~mask);
endmodule

// File: rtl/xnor_pattern_matcher.sv
// xnor_pattern_matcher: streaming masked XNOR comparator with run detector and saturating match counter.
// Define XNOR_SIMILARITY_EN to add the registered sim_bits popcount output.
module xnor_pattern_matcher import xnor_pkg::*; #(
    parameter int WIDTH   = WIDTH_D,
    parameter int RUN_LEN = RUN_LEN_D,
    parameter int CNT_W   = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_in,
    input  logic [WIDTH-1:0] mask_in,
    input  logic             clr,
    xnor_pattern_matcher_if.slave s,
    output logic [CNT_W-1:0] match_cnt
`ifdef XNOR_SIMILARITY_EN
    ,
    output logic [pop_w(WIDTH)-1:0] sim_bits
`endif
);
    localparam int KW = $clog2(RUN_LEN + 1);
    logic [WIDTH-1:0] pattern, mask, x;
    logic             m, accept;
    state_t           state, state_nxt;
    logic [KW-1:0]    k, k_nxt;

    assign s.in_ready = !s.out_valid || s.out_ready;
    assign accept     = s.in_valid && s.in_ready;

    xnor_vec #(.WIDTH(WIDTH)) u_vec (
        .data(s.in_data), .pattern(pattern), .mask(mask), .xnor_bits(x), .match(m)
    );

    // k counts matching words seen so far in the current run
    always_comb begin
        k_nxt     = '0;
        state_nxt = IDLE;
        if (m && state != HIT) begin
            k_nxt     = state == IDLE ? KW'(1) : k + KW'(1);
            state_nxt = int'(k_nxt) >= RUN_LEN ? HIT : COUNT;
        end else if (m) begin
            state_nxt = HIT;
        end
    end

`ifdef XNOR_SIMILARITY_EN
    logic [pop_w(WIDTH)-1:0] pc;
    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + (pop_w(WIDTH))'(x[i] & mask[i]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sim_bits <= '0;
        else if (accept) sim_bits <= pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern     <= '0;
            mask        <= '1;
            state       <= IDLE;
            k           <= '0;
            s.out_valid <= 1'b0;
            s.xnor_out  <= '0;
            s.match     <= 1'b0;
            s.run_hit   <= 1'b0;
            match_cnt   <= '0;
        end else begin
            if (pat_load) begin
                pattern <= pat_in;
                mask    <= mask_in;
            end
            if (accept) begin
                s.xnor_out <= x;
                s.match    <= m;
                s.run_hit  <= !pat_load && state_nxt == HIT;
            end
            // a pattern reload restarts the run even when a word is accepted alongside it
            state       <= pat_load ? IDLE : accept ? state_nxt : state;
            k           <= pat_load ? '0 : accept ? k_nxt : k;
            s.out_valid <= accept || (s.out_valid && !s.out_ready);
            match_cnt   <= clr ? '0 : (accept && m && !(&match_cnt)) ? match_cnt + CNT_W'(1) : match_cnt;
        end
    end
endmodule

// File: tb/tb_xnor_pattern_matcher.sv
// tb_xnor_pattern_matcher: scoreboard bench with directed scenario tasks for xnor_pattern_matcher.
module tb_xnor_pattern_matcher;
    import xnor_pkg::*;
    localparam int W = 8, RL = 3, CW = 4;

    logic clk = 1'b0, rst_n = 1'b0, pat_load = 1'b0, clr = 1'b0;
    logic [W-1:0] pat_in = '0, mask_in = '0;
    logic [CW-1:0] match_cnt;
`ifdef XNOR_SIMILARITY_EN
    logic [pop_w(W)-1:0] sim_bits;
`endif
    int vectors = 0, errors = 0;

    typedef struct packed { logic [W-1:0] x; logic m; logic rh; } exp_t;
    exp_t q[$];
    exp_t e, n;
    logic ov_m, acc;
    logic [W-1:0] pat_m, mask_m;
    logic [CW-1:0] cnt_m;
    int r_m;

    xnor_pattern_matcher_if #(.WIDTH(W)) bus ();

    xnor_pattern_matcher #(.WIDTH(W), .RUN_LEN(RL), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pat_load(pat_load), .pat_in(pat_in), .mask_in(mask_in),
        .clr(clr), .s(bus), .match_cnt(match_cnt)
`ifdef XNOR_SIMILARITY_EN
        , .sim_bits(sim_bits)
`endif
    );

    always #5 clk = ~clk;

    // reference model and scoreboard, evaluated mid-cycle while inputs are stable
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            ov_m = 1'b0; pat_m = '0; mask_m = '1; cnt_m = '0; r_m = 0;
        end else begin
            vectors++;
            if (bus.out_valid !== ov_m) begin errors++; $display("FAIL out_valid got %b want %b", bus.out_valid, ov_m); end
            vectors++;
            if (bus.in_ready !== (!ov_m || bus.out_ready)) begin errors++; $display("FAIL in_ready got %b want %b", bus.in_ready, !ov_m || bus.out_ready); end
            vectors++;
            if (match_cnt !== cnt_m) begin errors++; $display("FAIL match_cnt got %0d want %0d", match_cnt, cnt_m); end
            if (ov_m) begin
                vectors++;
                if (q.size() == 0) begin errors++; $display("FAIL scoreboard empty while out_valid"); end
                else begin
                    e = q[0];
                    if ({bus.xnor_out, bus.match, bus.run_hit} !== e) begin
                        errors++;
                        $display("FAIL result got x=%h m=%b rh=%b want x=%h m=%b rh=%b",
                                 bus.xnor_out, bus.match, bus.run_hit, e.x, e.m, e.rh);
                    end
                    if (bus.out_ready) void'(q.pop_front());
                end
            end
            acc = bus.in_valid && (!ov_m || bus.out_ready);
            if (acc) begin
                n.x = ~(bus.in_data ^ pat_m);
                n.m = &(n.x | ~mask_m);
                r_m = pat_load ? 0 : !n.m ? 0 : (r_m < RL ? r_m + 1 : r_m);
                n.rh = r_m >= RL;
                q.push_back(n);
            end
            cnt_m = clr ? '0 : (acc && n.m && cnt_m != '1) ? cnt_m + 1'b1 : cnt_m;
            if (pat_load) begin pat_m = pat_in; mask_m = mask_in; r_m = 0; end
            ov_m = acc || (ov_m && !bus.out_ready);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        bus.in_valid = 1'b1; bus.in_data = d;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] p, input logic [W-1:0] mk);
        pat_load = 1'b1; pat_in = p; mask_in = mk;
        tick();
        pat_load = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({bus.out_valid, bus.xnor_out, bus.match, bus.run_hit, match_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ov=%b x=%h m=%b rh=%b cnt=%0d want all 0",
                     bus.out_valid, bus.xnor_out, bus.match, bus.run_hit, match_cnt);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        send(8'h00);
        vectors++;
        if ({bus.xnor_out, bus.match, bus.run_hit, match_cnt} !== {8'hFF, 1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL basic got x=%h m=%b rh=%b cnt=%0d want x=ff m=1 rh=0 cnt=1",
                     bus.xnor_out, bus.match, bus.run_hit, match_cnt);
        end
        tick();
    endtask

    task automatic test_mask();
        load(8'hA5, 8'hF0);
        send(8'hA3);
        vectors++;
        if ({bus.xnor_out, bus.match, match_cnt} !== {8'hF9, 1'b1, 4'd2}) begin
            errors++; $display("FAIL mask_a3 got x=%h m=%b cnt=%0d want f9 1 2", bus.xnor_out, bus.match, match_cnt);
        end
        send(8'h55);
        vectors++;
        if ({bus.xnor_out, bus.match, match_cnt} !== {8'h0F, 1'b0, 4'd2}) begin
            errors++; $display("FAIL mask_55 got x=%h m=%b cnt=%0d want 0f 0 2", bus.xnor_out, bus.match, match_cnt);
        end
        tick();
    endtask

    task automatic test_run();
        logic [4:0] want = 5'b00110;
        logic [W-1:0] d;
        load(8'h3C, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            d = (i == 4) ? 8'h00 : 8'h3C;
            bus.in_valid = 1'b1; bus.in_data = d;
            tick();
            vectors++;
            if (bus.run_hit !== want[4-i]) begin errors++; $display("FAIL run_hit[%0d] got %b want %b", i, bus.run_hit, want[4-i]); end
        end
        bus.in_valid = 1'b0;
        vectors++;
        if (match_cnt !== 4'd6) begin errors++; $display("FAIL run_cnt got %0d want 6", match_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [4] = '{8'h3C, 8'h11, 8'h3C, 8'h3C};
        bus.in_valid = 1'b1; bus.in_data = words[0];
        tick();
        bus.out_ready = 1'b0; bus.in_data = words[1];
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.xnor_out !== 8'hFF || bus.out_valid !== 1'b1) begin
                errors++; $display("FAIL stall[%0d] got rdy=%b x=%h ov=%b want 0 ff 1", i, bus.in_ready, bus.xnor_out, bus.out_valid);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            bus.in_data = words[i];
            tick();
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (q.size() != 0 || match_cnt !== 4'd9) begin
            errors++; $display("FAIL b2b_drain got pending=%0d cnt=%0d want 0 9", q.size(), match_cnt);
        end
    endtask

    task automatic test_patload_same_cycle();
        pat_load = 1'b1; pat_in = 8'hFF; mask_in = 8'hFF;
        bus.in_valid = 1'b1; bus.in_data = 8'h3C;
        tick();
        pat_load = 1'b0;
        vectors++;
        if ({bus.xnor_out, bus.match, bus.run_hit} !== {8'hFF, 1'b1, 1'b0}) begin
            errors++; $display("FAIL patload_old got x=%h m=%b rh=%b want ff 1 0", bus.xnor_out, bus.match, bus.run_hit);
        end
        bus.in_data = 8'hFF;
        repeat (2) tick();
        vectors++;
        if (bus.run_hit !== 1'b0) begin errors++; $display("FAIL patload_run2 got %b want 0", bus.run_hit); end
        tick();
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.run_hit !== 1'b1) begin errors++; $display("FAIL patload_run3 got %b want 1", bus.run_hit); end
        tick();
    endtask

    task automatic test_saturate();
        bus.in_valid = 1'b1; bus.in_data = 8'hFF;
        repeat (20) tick();
        vectors++;
        if (match_cnt !== 4'hF) begin errors++; $display("FAIL saturate got %0d want 15", match_cnt); end
        clr = 1'b1;
        tick();
        clr = 1'b0; bus.in_valid = 1'b0;
        vectors++;
        if (match_cnt !== 4'd0) begin errors++; $display("FAIL clr_priority got %0d want 0", match_cnt); end
        tick();
    endtask

    task automatic test_midstream_reset();
        bus.out_ready = 1'b0;
        send(8'h12);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.out_valid !== 1'b0 || match_cnt !== '0) begin
            errors++; $display("FAIL async_reset got ov=%b cnt=%0d want 0 0", bus.out_valid, match_cnt);
        end
        tick();
        rst_n = 1'b1; bus.out_ready = 1'b1;
        tick();
        send(8'h00);
        vectors++;
        if ({bus.xnor_out, bus.match} !== {8'hFF, 1'b1}) begin
            errors++; $display("FAIL reset_pattern got x=%h m=%b want ff 1", bus.xnor_out, bus.match);
        end
        tick();
    endtask

`ifdef XNOR_SIMILARITY_EN
    task automatic test_similarity();
        load(8'hA5, 8'hFF);
        send(8'hA3);
        vectors++;
        if ({bus.xnor_out, bus.match, sim_bits} !== {8'hF9, 1'b0, 4'd6}) begin
            errors++; $display("FAIL sim_bits got x=%h m=%b sb=%0d want f9 0 6", bus.xnor_out, bus.match, sim_bits);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mask();
        test_run();
        test_back_to_back();
        test_patload_same_cycle();
        test_saturate();
        test_midstream_reset();
`ifdef XNOR_SIMILARITY_EN
        test_similarity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
